// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int BUS_WIDTH = 32;
    localparam logic [BUS_WIDTH-1:0] RESET_PC_DEFAULT = '0;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] inst;
        logic [BUS_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch unit (master), instruction memory and the IR (slave side).
// imem: a request transfers when imem_req && imem_gnt; responses follow in order via imem_rvalid.
// inst: a transfer happens when inst_valid && inst_ready; the payload holds while valid and unpopped.
interface inst_fetch_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 imem_req;
    logic [BUS_WIDTH-1:0] imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [BUS_WIDTH-1:0] imem_rdata;
    logic                 inst_valid;
    logic [BUS_WIDTH-1:0] inst_out;
    logic [BUS_WIDTH-1:0] inst_pc;
    logic                 inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

endinterface

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush; flush overrides push and pop in the same cycle.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, credit-gated memory requests, in-order buffer, redirect flush.
// Optional IFU_BYPASS_EN presents a response to the IR in its arrival cycle when the buffer is empty.
module inst_fetch
    import ifu_pkg::*;
#(
    parameter int                   BUS_WIDTH  = ifu_pkg::BUS_WIDTH,
    parameter logic [BUS_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_valid,
    input  logic [BUS_WIDTH-1:0] redirect_pc,
    inst_fetch_if.master         bus,
    output ifu_state_e           state_dbg
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    ifu_state_e           state_q, state_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [CW-1:0]        discard_q, discard_d;

    logic                 req, grant, rsp_take, inst_valid;
    fetch_entry_t         rsp_entry, out_entry, ibuf_rdata;
    logic                 ibuf_push, ibuf_pop, ibuf_full, ibuf_empty;
    logic [CW-1:0]        ibuf_count;
    logic [BUS_WIDTH-1:0] rsp_pc;
    logic                 aq_full, aq_empty;
    logic [CW-1:0]        aq_count;
    logic                 unused_flags;

    // Buffered plus in-flight instructions never exceed FIFO_DEPTH, so a push always finds room.
    assign req       = rst_n && (state_q == FETCH)
                       && ((SW'(outstanding_q) + SW'(ibuf_count)) < SW'(FIFO_DEPTH));
    assign grant     = req && bus.imem_gnt;
    assign rsp_take  = bus.imem_rvalid && (discard_q == '0);
    assign rsp_entry = '{inst: bus.imem_rdata, pc: rsp_pc};

`ifdef IFU_BYPASS_EN
    logic bypass;
    assign bypass     = rsp_take && ibuf_empty;
    assign inst_valid = !ibuf_empty || bypass;
    assign out_entry  = ibuf_empty ? rsp_entry : ibuf_rdata;
    assign ibuf_push  = rsp_take && !(bypass && bus.inst_ready);
    assign ibuf_pop   = !ibuf_empty && bus.inst_ready;
`else
    assign inst_valid = !ibuf_empty;
    assign out_entry  = ibuf_rdata;
    assign ibuf_push  = rsp_take;
    assign ibuf_pop   = !ibuf_empty && bus.inst_ready;
`endif

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = inst_valid;
    assign bus.inst_out   = inst_valid ? out_entry.inst : '0;
    assign bus.inst_pc    = inst_valid ? out_entry.pc : '0;
    assign state_dbg      = state_q;
    assign unused_flags   = ^{aq_full, aq_empty, aq_count, ibuf_full};

    ifu_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ibuf_push),
        .wdata (rsp_entry),
        .pop   (ibuf_pop),
        .flush (redirect_valid),
        .rdata (ibuf_rdata),
        .count (ibuf_count),
        .full  (ibuf_full),
        .empty (ibuf_empty)
    );

    // Address queue pairs each response with its request; it survives redirects so stale responses still pop it.
    ifu_fifo #(
        .WIDTH(BUS_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_addr_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .wdata (pc_q),
        .pop   (bus.imem_rvalid),
        .flush (1'b0),
        .rdata (rsp_pc),
        .count (aq_count),
        .full  (aq_full),
        .empty (aq_empty)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(bus.imem_rvalid);
        discard_d     = discard_q;

        if (grant) begin
            pc_d = pc_q + BUS_WIDTH'(4);
        end
        if (bus.imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        if (redirect_valid) begin
            pc_d      = {redirect_pc[BUS_WIDTH-1:2], 2'b00};
            discard_d = outstanding_d;
            state_d   = (outstanding_d != '0) ? DRAIN : FETCH;
        end else if ((state_q == DRAIN) && (discard_d == '0)) begin
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule
